ambulance_detector: RTL and testbench

- Siren-presence qualifier in the traffic controller.
- Samples a 1-bit digitised sound indication once per clock and counts consecutive high samples.
- On the THRESHOLD-th consecutive high sample, emits a single-cycle detection pulse that the signal-phase controller uses to grant emergency priority.
- Emits at most one pulse per unbroken run of highs; a low sample re-arms the detector.

---
 rtl/ambulance_detector.sv | 75 +++++++
 tb/tb_ambulance_detector.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ambulance_detector.sv
// ambulance_detector: siren-presence qualifier.
// Counts consecutive high sound samples and emits a single-cycle registered
// pulse on the THRESHOLD-th consecutive high. One pulse per unbroken run of
// highs; any low sample re-arms the detector.
// Optional feature macro AMBULANCE_DETECT_COUNT_EN adds an 8-bit saturating
// detect_count output counting pulses since reset.
// There are no handshakes here: sound_in is a plain per-cycle sample and
// ambulance_detected is a one-cycle strobe with no back-pressure.
module ambulance_detector #(
   parameter int THRESHOLD = 3,
   parameter int CNT_W     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sound_in,
`ifdef AMBULANCE_DETECT_COUNT_EN
   output logic [7:0] detect_count,
`endif
   output logic       ambulance_detected
);

   // Counter value on which the next high sample completes a qualifying run.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESHOLD - 1);

   // Run length of highs since the last low, detection or reset.
   logic [CNT_W-1:0] consecutive_count;
   // Set while a detection may still fire in the current run.
   logic             armed;
   // High when this edge's sample completes a qualifying run.
   logic             hit;

   // Detection condition shared by the pulse register and the optional counter.
   always_comb begin
      hit = 1'b0;
      if (sound_in && armed && (consecutive_count == LAST_CNT)) begin
         hit = 1'b1;
      end
   end

   // Run counter, arming flag and registered detection pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         consecutive_count  <= '0;
         armed              <= 1'b1;
         ambulance_detected <= 1'b0;
      end else if (!sound_in) begin
         consecutive_count  <= '0;
         armed              <= 1'b1;
         ambulance_detected <= 1'b0;
      end else if (hit) begin
         // Disarm so the rest of a long run cannot fire again.
         consecutive_count  <= '0;
         armed              <= 1'b0;
         ambulance_detected <= 1'b1;
      end else if (armed) begin
         consecutive_count  <= consecutive_count + CNT_W'(1);
         ambulance_detected <= 1'b0;
      end else begin
         consecutive_count  <= '0;
         ambulance_detected <= 1'b0;
      end
   end

`ifdef AMBULANCE_DETECT_COUNT_EN
   // Saturating count of detection pulses since reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         detect_count <= 8'd0;
      end else if (hit && (detect_count != 8'hFF)) begin
         detect_count <= detect_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ambulance_detector.sv
// tb_ambulance_detector: bench for ambulance_detector.
// The reference model tracks the raw length of the current run of highs as an
// integer; a pulse is due exactly when that length reaches THRESHOLD, and the
// observable counter equals the run length only while it is below THRESHOLD.
module tb_ambulance_detector;

   localparam int THRESHOLD = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       sound_in;
   logic       ambulance_detected;
`ifdef AMBULANCE_DETECT_COUNT_EN
   logic [7:0] detect_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state.
   int   run_len = 0;
   int   pulses  = 0;
   logic exp_q[$];

   ambulance_detector #(.THRESHOLD(THRESHOLD), .CNT_W(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .sound_in           (sound_in),
`ifdef AMBULANCE_DETECT_COUNT_EN
      .detect_count       (detect_count),
`endif
      .ambulance_detected (ambulance_detected)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Compare all visible state against the model.
   task automatic check_outputs(input string tag);
      logic e_pulse;
      int   e_cnt;
      int   e_det;
      e_pulse = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      e_cnt   = (run_len < THRESHOLD) ? run_len : 0;
      e_det   = (pulses > 255) ? 255 : pulses;
      check({tag, "_pulse"}, 32'(ambulance_detected), 32'(e_pulse));
      check({tag, "_count"}, 32'(dut.consecutive_count), 32'(e_cnt));
`ifdef AMBULANCE_DETECT_COUNT_EN
      check({tag, "_dcnt"}, 32'(detect_count), 32'(e_det));
`else
      if (e_det < 0) $display("model pulse count negative");
`endif
   endtask

   // One sample: drive at the falling edge, model at the rising edge, check at the next falling edge.
   task automatic drive(input logic s, input string tag);
      logic p;
      sound_in = s;
      @(posedge clk);
      if (s) begin
         if (run_len < 1000) run_len++;
      end else begin
         run_len = 0;
      end
      p = s && (run_len == THRESHOLD);
      if (p) pulses++;
      exp_q.push_back(p);
      @(negedge clk);
      check_outputs(tag);
   endtask

   // Apply n samples, MSB of bits first.
   task automatic run_pattern(input logic [15:0] bits, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         drive(bits[i], tag);
      end
   endtask

   // Asynchronous reset asserted between edges; checked before any edge arrives.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      run_len = 0;
      pulses  = 0;
      exp_q.delete();
      #1;
      check("async_rst_pulse", 32'(ambulance_detected), 32'd0);
      check("async_rst_count", 32'(dut.consecutive_count), 32'd0);
`ifdef AMBULANCE_DETECT_COUNT_EN
      check("async_rst_dcnt", 32'(detect_count), 32'd0);
`endif
      sound_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_outputs("in_reset");
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      sound_in = 1'b0;
      @(negedge clk);
      do_reset();

      // Exact run, short run, long run, interrupted pattern.
      run_pattern(16'b1110, 4, "exact");
      run_pattern(16'b110, 3, "short");
      run_pattern(16'b1111110, 7, "long");
      run_pattern(16'b101101110, 9, "interrupt");
`ifdef AMBULANCE_DETECT_COUNT_EN
      check("dcnt_after_scenarios", 32'(detect_count), 32'd3);
`endif

      // Reset while a pulse is high and while a run is in progress.
      run_pattern(16'b111, 3, "pre_rst_pulse");
      do_reset();
      run_pattern(16'b11, 2, "pre_rst_mid");
      do_reset();
      run_pattern(16'b1110, 4, "post_rst_fresh");

      // Many pulses to drive the optional counter into saturation.
      repeat (256) run_pattern(16'b1110, 4, "sat");
`ifdef AMBULANCE_DETECT_COUNT_EN
      check("dcnt_saturated", 32'(detect_count), 32'd255);
`endif

      // Randomized samples with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            drive(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0, "rand");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
